fp_multiplier_seq: RTL

//   Sequential IEEE-754 single-precision multiplier; the inverse operation of fp_divider in the FP unit.

---
 rtl/fp_multiplier_seq_if.sv | 12 +
 rtl/fp_multiplier_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fp_multiplier_seq_if.sv
// Handshake/operand bundle between the FP control sequencer and the sequential multiplier.
interface fp_multiplier_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Out;
  logic        busy;
  logic        done;

  modport master (output start, A, B, input Out, busy, done);
  modport slave  (input start, A, B, output Out, busy, done);
endinterface

// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE single multiplier: one shift-add partial product per cycle, truncating
// normalize, fixed 26-cycle latency from the accepting edge to the done pulse.
module fp_multiplier_seq #(
  parameter int EXP_BIAS = 127,
  parameter int MANT_W   = 24
) (
  input logic                  int_clk,
  input logic                  rst_n,
  fp_multiplier_seq_if.slave   bus
);
  localparam int ACC_W = 2 * MANT_W;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [MANT_W-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d, out_q, out_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic signed [9:0]  exp_raw, exp_n;
  logic [MANT_W-2:0]  mant;
  logic               a_inf, b_inf, a_zero, b_zero;

  assign bus.Out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Exponent/mantissa selection from the finished accumulator; only consumed in NORM.
  always_comb begin
    a_inf   = (ea_q == 8'hFF);
    b_inf   = (eb_q == 8'hFF);
    a_zero  = (ea_q == 8'h00);
    b_zero  = (eb_q == 8'h00);
    exp_raw = 10'({2'b00, ea_q}) + 10'({2'b00, eb_q}) - 10'(EXP_BIAS);
    if (acc_q[ACC_W-1]) begin
      exp_n = exp_raw + 10'sd1;
      mant  = acc_q[ACC_W-2 -: (MANT_W-1)];
    end else begin
      exp_n = exp_raw;
      mant  = acc_q[ACC_W-3 -: (MANT_W-1)];
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.A[31] ^ bus.B[31];
          ea_d    = bus.A[30:23];
          eb_d    = bus.B[30:23];
          ma_d    = {1'b1, bus.A[22:0]};
          mb_d    = {1'b1, bus.B[22:0]};
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mb_q[0]) acc_d = acc_q + (ACC_W'(ma_q) << cnt_q);
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MANT_W - 1)) state_d = NORM;
      end
      NORM: begin
        // Infinity times zero is the only invalid product; other NaNs collapse to infinity.
        if ((a_inf && b_zero) || (b_inf && a_zero)) res_d = 32'h7FC0_0000;
        else if (a_inf || b_inf)                    res_d = {sign_q, 8'hFF, 23'h0};
        else if (a_zero || b_zero)                  res_d = {sign_q, 31'h0};
        else if (exp_n >= 10'sd255)                 res_d = {sign_q, 8'hFF, 23'h0};
        else if (exp_n <= 10'sd0)                   res_d = {sign_q, 31'h0};
        else                                        res_d = {sign_q, exp_n[7:0], mant};
        state_d = DONE;
      end
      DONE: begin
        out_d   = res_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
